// File: rtl/vga_scan_controller_if.sv
// Line-fetch handshake between the VGA scan controller (master) and the
// framebuffer / line-buffer fetch engine (slave).
`timescale 1ns/1ps

interface vga_scan_controller_if #(
    parameter int unsigned P_CNT_WIDTH = 10
);
    logic                   o_fetch_req;
    logic [P_CNT_WIDTH-1:0] o_fetch_line;
    logic                   i_fetch_ack;

    modport master (
        output o_fetch_req,
        output o_fetch_line,
        input  i_fetch_ack
    );

    modport slave (
        input  o_fetch_req,
        input  o_fetch_line,
        output i_fetch_ack
    );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA horizontal/vertical timing with one line-fetch request per visible line.
// Optional feature: VGA_SCAN_UNDERRUN_DETECT_EN enables the end-of-line fetch deadline and o_underrun.
`timescale 1ns/1ps

module vga_scan_controller #(
    parameter int unsigned P_CNT_WIDTH     = 10,
    parameter int unsigned P_H_VISIBLE     = 640,
    parameter int unsigned P_H_FRONT_PORCH = 16,
    parameter int unsigned P_H_SYNC        = 96,
    parameter int unsigned P_H_BACK_PORCH  = 48,
    parameter int unsigned P_V_VISIBLE     = 480,
    parameter int unsigned P_V_FRONT_PORCH = 10,
    parameter int unsigned P_V_SYNC        = 2,
    parameter int unsigned P_V_BACK_PORCH  = 33,
    parameter bit          P_SYNC_POL      = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic                   o_visible,
    output logic [P_CNT_WIDTH-1:0] o_x,
    output logic [P_CNT_WIDTH-1:0] o_y,
    output logic                   o_frame_start,
    vga_scan_controller_if.master  fetch,
    output logic                   o_underrun
);
    localparam int unsigned H_TOTAL    = P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC + P_H_BACK_PORCH;
    localparam int unsigned V_TOTAL    = P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC + P_V_BACK_PORCH;
    localparam int unsigned H_SYNC_BEG = P_H_VISIBLE + P_H_FRONT_PORCH;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + P_H_SYNC;
    localparam int unsigned V_SYNC_BEG = P_V_VISIBLE + P_V_FRONT_PORCH;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + P_V_SYNC;
    localparam int unsigned CNT_RANGE  = 1 << P_CNT_WIDTH;

    if (H_TOTAL > CNT_RANGE || V_TOTAL > CNT_RANGE) begin : g_range_check
        $error("vga_scan_controller: H_TOTAL/V_TOTAL exceed counter range of P_CNT_WIDTH");
    end

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } fetch_state_e;

    logic [P_CNT_WIDTH-1:0] h_cnt;
    logic [P_CNT_WIDTH-1:0] v_cnt;
    logic [P_CNT_WIDTH-1:0] line_q;
    logic [P_CNT_WIDTH-1:0] line_d;
    int unsigned            h_pos;
    int unsigned            v_pos;
    int unsigned            next_line;
    logic                   h_last;
    logic                   v_last;
    logic                   underrun_d;
    fetch_state_e           state_q;
    fetch_state_e           state_d;

    always_comb begin
        h_pos     = 32'(h_cnt);
        v_pos     = 32'(v_cnt);
        h_last    = (h_pos == H_TOTAL - 1);
        v_last    = (v_pos == V_TOTAL - 1);
        next_line = v_last ? 0 : v_pos + 1;
    end

    // NOTE: every variable gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Fetch for the line after this one, launched once its visible part is done.
                if (h_pos == P_H_VISIBLE && next_line < P_V_VISIBLE) begin
                    state_d = ST_REQ;
                    line_d  = P_CNT_WIDTH'(next_line);
                end
            end
            ST_REQ: begin
                if (fetch.i_fetch_ack) begin
                    state_d = ST_IDLE;
                end
`ifdef VGA_SCAN_UNDERRUN_DETECT_EN
                else if (h_last) begin
                    state_d    = ST_IDLE;
                    underrun_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            state_q       <= ST_IDLE;
            line_q        <= '0;
            o_h_sync      <= ~P_SYNC_POL;
            o_v_sync      <= ~P_SYNC_POL;
            o_visible     <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else if (i_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
            state_q       <= state_d;
            line_q        <= line_d;
            o_h_sync      <= (h_pos >= H_SYNC_BEG && h_pos < H_SYNC_END) ? P_SYNC_POL : ~P_SYNC_POL;
            o_v_sync      <= (v_pos >= V_SYNC_BEG && v_pos < V_SYNC_END) ? P_SYNC_POL : ~P_SYNC_POL;
            o_visible     <= (h_pos < P_H_VISIBLE) && (v_pos < P_V_VISIBLE);
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= (h_pos == 0) && (v_pos == 0);
            o_underrun    <= underrun_d;
        end else begin
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end
    end

    assign fetch.o_fetch_req  = (state_q == ST_REQ);
    assign fetch.o_fetch_line = line_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller on an 8x6 toy timing (H 4/1/2/1, V 3/1/1/1).
`timescale 1ns/1ps

module tb_vga_scan_controller;
    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         h_sync;
    logic         v_sync;
    logic         visible;
    logic         frame_start;
    logic         underrun;
    logic [W-1:0] x;
    logic [W-1:0] y;

    vga_scan_controller_if #(.P_CNT_WIDTH(W)) fetch_if ();

    vga_scan_controller #(
        .P_CNT_WIDTH    (W),
        .P_H_VISIBLE    (4),
        .P_H_FRONT_PORCH(1),
        .P_H_SYNC       (2),
        .P_H_BACK_PORCH (1),
        .P_V_VISIBLE    (3),
        .P_V_FRONT_PORCH(1),
        .P_V_SYNC       (1),
        .P_V_BACK_PORCH (1),
        .P_SYNC_POL     (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .o_h_sync     (h_sync),
        .o_v_sync     (v_sync),
        .o_visible    (visible),
        .o_x          (x),
        .o_y          (y),
        .o_frame_start(frame_start),
        .fetch        (fetch_if),
        .o_underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit vis;
        bit hs;
        bit vs;
        bit fs;
    } timing_t;

    // rise_c/fall_c are linear positions y*8+x shown on the outputs; fall_c -1 means dropped by reset.
    typedef struct {
        int line;
        int rise_c;
        int fall_c;
    } fetch_t;

    typedef enum {ACK_TIED, ACK_NONE, ACK_DELAY1, ACK_AT6} ack_mode_e;

    timing_t   tq[$];
    fetch_t    fq[$];
    int        uq[$];
    ack_mode_e ack_mode = ACK_NONE;
    int        total    = 0;
    int        bad      = 0;
    int        mh       = 0;
    int        mv       = 0;
    timing_t   last_exp;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference timing: visible h<4 & v<3, hsync low at h 5..6, vsync low on line 4.
    function automatic timing_t expect_at(input int h, input int v);
        timing_t e;
        e.x   = h;
        e.y   = v;
        e.vis = (h < 4) && (v < 3);
        e.hs  = !(h == 5 || h == 6);
        e.vs  = (v != 4);
        e.fs  = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic push_timing(input bit e);
        if (e) begin
            last_exp = expect_at(mh, mv);
            mh++;
            if (mh == 8) begin
                mh = 0;
                mv = (mv + 1) % 6;
            end
        end else begin
            last_exp.fs = 1'b0;
        end
        tq.push_back(last_exp);
    endtask

    task automatic cycle(input bit e);
        en = e;
        @(posedge clk);
        push_timing(e);
        #1;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) cycle(e);
    endtask

    task automatic push_fetch(input int line, input int rise_c, input int fall_c);
        fetch_t f;
        f.line   = line;
        f.rise_c = rise_c;
        f.fall_c = fall_c;
        fq.push_back(f);
    endtask

    task automatic push_frame_fetches();
        push_fetch(1, 4, 5);
        push_fetch(2, 12, 13);
        push_fetch(0, 44, 45);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("reset_sync", 32'({h_sync, v_sync}), 32'(2'b11));
        check("reset_area", 32'({visible, frame_start, x, y}), 32'd0);
        check("reset_fetch", 32'({fetch_if.o_fetch_req, fetch_if.o_fetch_line, underrun}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mh    = 0;
        mv    = 0;
    endtask

    // Fetch-engine model: ack policy selected by the stimulus process.
    initial begin
        fetch_if.i_fetch_ack = 1'b0;
        forever begin
            @(negedge clk);
            case (ack_mode)
                ACK_TIED:   fetch_if.i_fetch_ack = 1'b1;
                ACK_NONE:   fetch_if.i_fetch_ack = 1'b0;
                ACK_DELAY1: fetch_if.i_fetch_ack = fetch_if.o_fetch_req;
                ACK_AT6:    fetch_if.i_fetch_ack = fetch_if.o_fetch_req && (x == 4'd6);
                default:    fetch_if.i_fetch_ack = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations as the DUT presents cycles, fetch edges and underrun pulses.
    bit      mon_prev_req = 1'b0;
    bit      mon_in_req   = 1'b0;
    fetch_t  mon_cur;
    timing_t mon_e;
    int      mon_c;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (mon_in_req) check("fetch_abort_by_reset", 32'(mon_cur.fall_c), 32'(-1));
                mon_in_req   = 1'b0;
                mon_prev_req = 1'b0;
            end else begin
                mon_c = int'(y) * 8 + int'(x);
                if (tq.size() > 0) begin
                    mon_e = tq.pop_front();
                    check("timing", 32'({x, y, visible, h_sync, v_sync, frame_start}),
                          32'({4'(mon_e.x), 4'(mon_e.y), mon_e.vis, mon_e.hs, mon_e.vs, mon_e.fs}));
                end
                if (fetch_if.o_fetch_req && !mon_prev_req) begin
                    check("fetch_rise_expected", 32'(fq.size() > 0), 32'd1);
                    if (fq.size() > 0) begin
                        mon_cur = fq.pop_front();
                        check("fetch_rise", 32'({fetch_if.o_fetch_line, 8'(mon_c)}),
                              32'({4'(mon_cur.line), 8'(mon_cur.rise_c)}));
                        mon_in_req = 1'b1;
                    end
                end else if (fetch_if.o_fetch_req && mon_in_req) begin
                    check("fetch_line_stable", 32'(fetch_if.o_fetch_line), 32'(mon_cur.line));
                end
                if (!fetch_if.o_fetch_req && mon_prev_req && mon_in_req) begin
                    check("fetch_fall", 32'(mon_c), 32'(mon_cur.fall_c));
                    mon_in_req = 1'b0;
                end
                mon_prev_req = fetch_if.o_fetch_req;
                if (underrun) begin
                    check("underrun_expected", 32'(uq.size() > 0), 32'd1);
                    if (uq.size() > 0) check("underrun_pos", 32'(mon_c), 32'(uq.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two full frames with ack tied high.
        ack_mode = ACK_TIED;
        do_reset();
        push_frame_fetches();
        push_frame_fetches();
        run(96, 1'b1);

        // Ack one cycle after the request appears.
        ack_mode = ACK_DELAY1;
        do_reset();
        push_frame_fetches();
        run(50, 1'b1);

        // Ack withheld for line 1, then normal service for line 2.
        ack_mode = ACK_NONE;
        do_reset();
`ifdef VGA_SCAN_UNDERRUN_DETECT_EN
        push_fetch(1, 4, 7);
        uq.push_back(7);
`else
        push_fetch(1, 4, 10);
`endif
        push_fetch(2, 12, 13);
        run(10, 1'b1);
        ack_mode = ACK_DELAY1;
        run(10, 1'b1);

        // Ack lands on the deadline cycle (h_cnt 7): ack wins.
        ack_mode = ACK_AT6;
        do_reset();
        push_fetch(1, 4, 7);
        push_fetch(2, 12, 15);
        run(20, 1'b1);

        // Enable gaps: right after frame start, and for 10 cycles while a request is pending.
        ack_mode = ACK_TIED;
        do_reset();
        push_frame_fetches();
        run(1, 1'b1);
        run(2, 1'b0);
        run(4, 1'b1);
        run(10, 1'b0);
        run(45, 1'b1);

        // Reset while the line-1 request is outstanding.
        ack_mode = ACK_NONE;
        do_reset();
        push_fetch(1, 4, -1);
        run(6, 1'b1);
        check("req_before_reset", 32'(fetch_if.o_fetch_req), 32'd1);
        do_reset();
        ack_mode = ACK_TIED;
        run(3, 1'b1);

        @(negedge clk);
        #1;
        check("timing_queue_drained", 32'(tq.size()), 32'd0);
        check("fetch_queue_drained", 32'(fq.size()), 32'd0);
        check("underrun_queue_drained", 32'(uq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
